// File: rtl/mem_sram_access_pkg.sv
// Shared definitions for the memory-stage SRAM access block:
// FSM state type, SRAM bus geometry and the default SRAM base address.
package mem_sram_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/mem_sram_access_xlate.sv
// Byte-address to SRAM halfword-address translation.
// Optional macro ALIGN_CHECK_EN adds the misaligned/out-of-range flag.
module sram_addr_xlate
    import mem_sram_access_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic [31:0]        byte_addr,
    input  logic               phase,
    output logic [SRAM_AW-1:0] hw_addr
`ifdef ALIGN_CHECK_EN
    ,
    output logic               misaligned
`endif
);

    logic [31:0] offset;
    logic        unused_offset_bits;

    // Word index is the offset from the base, dropping the byte lane bits;
    // the phase selects the even (low) or odd (high) halfword of that word.
    always_comb begin
        offset             = byte_addr - BASE_ADDR;
        hw_addr            = {offset[SRAM_AW:2], phase};
        unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
    end

`ifdef ALIGN_CHECK_EN
    // Flag addresses that are not word aligned or fall below the SRAM window.
    always_comb begin
        misaligned = (byte_addr[1:0] != 2'b00) || (byte_addr < BASE_ADDR);
    end
`endif

endmodule

// File: rtl/mem_sram_access.sv
// Memory stage: 32-bit loads/stores on a 16-bit async SRAM as two halfword
// phases with WAIT_CYCLES extra cycles each, stalling the pipeline via freeze.
// Optional macro ALIGN_CHECK_EN adds a sticky mem_err output and suppresses
// misaligned or below-base requests.
module mem_sram_access
    import mem_sram_access_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        val_rm,
    output logic [31:0]        mem_result,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
`ifdef ALIGN_CHECK_EN
    ,
    output logic               mem_err
`endif
);

    localparam int unsigned   CW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 is_store;
    logic [SRAM_DW-1:0]   ld_low;
    logic                 req;
    logic                 start;
    logic                 phase_last;
    logic [SRAM_AW-1:0]   xlate_addr;

`ifdef ALIGN_CHECK_EN
    logic                 misaligned;
`endif

    // The address loaded at the end of LOW is the odd halfword; everywhere
    // else (including IDLE, which loads the LOW address) it is the even one.
    sram_addr_xlate #(
        .BASE_ADDR (BASE_ADDR)
    ) u_xlate (
        .byte_addr  (alu_result),
        .phase      (state == LOW),
        .hw_addr    (xlate_addr)
`ifdef ALIGN_CHECK_EN
        ,
        .misaligned (misaligned)
`endif
    );

    // Request decode and phase-end detection.
    always_comb begin
        req        = mem_r_en | mem_w_en;
`ifdef ALIGN_CHECK_EN
        start      = req & ~misaligned;
`else
        start      = req;
`endif
        phase_last = (cnt == CNT_LAST);
    end

    // Stall while an access is starting or in flight; never during reset.
    always_comb begin
        freeze = rst && (((state == IDLE) && start) || (state == LOW) || (state == HIGH));
    end

    // Access FSM, wait-state counter and registered SRAM/result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            is_store    <= 1'b0;
            ld_low      <= '0;
            mem_result  <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOW;
                        cnt       <= '0;
                        is_store  <= mem_w_en;
                        sram_addr <= xlate_addr;
                        if (mem_w_en) begin
                            sram_we_n   <= 1'b0;
                            sram_dq_oe  <= 1'b1;
                            sram_dq_out <= val_rm[15:0];
                        end else begin
                            sram_oe_n   <= 1'b0;
                        end
                    end
                end
                LOW: begin
                    if (phase_last) begin
                        state     <= HIGH;
                        cnt       <= '0;
                        sram_addr <= xlate_addr;
                        if (is_store) begin
                            sram_dq_out <= val_rm[31:16];
                        end else begin
                            ld_low      <= sram_dq_in;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HIGH: begin
                    if (phase_last) begin
                        state      <= DONE;
                        cnt        <= '0;
                        sram_we_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        if (!is_store) begin
                            mem_result <= {sram_dq_in, ld_low};
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALIGN_CHECK_EN
    // Sticky error for rejected requests seen in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_err <= 1'b0;
        end else if ((state == IDLE) && req && misaligned) begin
            mem_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_sram_access.sv
// Self-checking bench for mem_sram_access with a behavioural SRAM and a
// word-level reference memory. Honours ALIGN_CHECK_EN when defined.
module tb_mem_sram_access;

    localparam int unsigned W     = 4;
    localparam logic [31:0] BASE  = 32'd1024;
    localparam int unsigned STALL = 2 * (W + 1) + 1;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_result;
    logic [31:0] val_rm;
    logic [31:0] mem_result;
    logic        freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;
`ifdef ALIGN_CHECK_EN
    logic        mem_err;
`endif

    int n_checks = 0;
    int n_err    = 0;

    mem_sram_access #(
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .alu_result  (alu_result),
        .val_rm      (val_rm),
        .mem_result  (mem_result),
        .freeze      (freeze),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
`ifdef ALIGN_CHECK_EN
        ,
        .mem_err     (mem_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural asynchronous SRAM: reads while OE is low, writes on clock
    // edges while WE is low and the bus is driven.
    logic [15:0] sram_mem [0:262143];
    assign sram_dq_in = sram_oe_n ? 16'hA5A5 : sram_mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
    end

    // Reference: halfword-indexed memory and last completed load value.
    logic [15:0] ref_mem [int unsigned];
    logic [31:0] exp_load;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned word_of(input logic [31:0] a);
        return ((a - BASE) / 4) % (1 << 17);
    endfunction

    // One complete access starting in IDLE at posedge+1; ends in IDLE at posedge+1.
    task automatic access(input bit r, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit keep_en);
        int unsigned w;
        int unsigned fcnt;
        bit          ph;
        w    = word_of(addr);
        fcnt = 0;
        if (wr) begin
            ref_mem[2*w]   = data[15:0];
            ref_mem[2*w+1] = data[31:16];
        end else begin
            exp_load = {ref_mem[2*w+1], ref_mem[2*w]};
        end
        mem_r_en   = r;
        mem_w_en   = wr;
        alu_result = addr;
        val_rm     = data;
        for (int k = 0; k <= int'(STALL); k++) begin
            @(negedge clk);
            check($sformatf("freeze k=%0d", k), {31'd0, freeze}, {31'd0, k < int'(STALL)});
            if (freeze) fcnt++;
            if (k >= 1 && k < int'(STALL)) begin
                ph = (k > int'(W) + 1);
                check($sformatf("addr k=%0d", k), {14'd0, sram_addr}, 2*w + ph);
                check($sformatf("we_n k=%0d", k), {31'd0, sram_we_n}, {31'd0, !wr});
                check($sformatf("oe_n k=%0d", k), {31'd0, sram_oe_n}, {31'd0, wr});
                check($sformatf("dq_oe k=%0d", k), {31'd0, sram_dq_oe}, {31'd0, wr});
                if (wr) check($sformatf("dq_out k=%0d", k), {16'd0, sram_dq_out},
                              {16'd0, ph ? data[31:16] : data[15:0]});
            end
            if (k == int'(STALL)) begin
                check("done_we_n", {31'd0, sram_we_n}, 32'd1);
                check("done_oe_n", {31'd0, sram_oe_n}, 32'd1);
                check("done_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
                check("done_result", mem_result, exp_load);
                check("freeze_len", fcnt, STALL);
            end
            @(posedge clk);
            #1;
            if (k == int'(STALL) - 1 && !keep_en) begin
                mem_r_en = 1'b0;
                mem_w_en = 1'b0;
            end
        end
    endtask

    initial begin : main
        int unsigned words[$];
        int unsigned w;
        logic [31:0] d;
        logic [31:0] a;

        rst        = 1'b0;
        mem_r_en   = 1'b1;
        mem_w_en   = 1'b0;
        alu_result = BASE;
        val_rm     = '0;
        exp_load   = '0;

        // Reset state, with a request pending to show freeze is held low.
        #12;
        check("rst_freeze", {31'd0, freeze}, 32'd0);
        check("rst_result", mem_result, 32'd0);
        check("rst_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
        check("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
`ifdef ALIGN_CHECK_EN
        check("rst_mem_err", {31'd0, mem_err}, 32'd0);
`endif
        mem_r_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed store/load pairs.
        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);
        check("sram_hw0", {16'd0, sram_mem[0]}, 32'h0000BEEF);
        check("sram_hw1", {16'd0, sram_mem[1]}, 32'h0000DEAD);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        access(1'b0, 1'b1, 32'd1036, 32'h12345678, 1'b0);
        check("sram_hw6", {16'd0, sram_mem[6]}, 32'h00005678);
        check("sram_hw7", {16'd0, sram_mem[7]}, 32'h00001234);
        access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);

        // Back-to-back load then store (both enables high => store).
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1);
        access(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 1'b0);
        access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0);

        // Randomized stores with read-back of earlier stored words.
        for (int i = 0; i < 10; i++) begin
            w = $urandom_range(10, 300);
            d = $urandom;
            a = BASE + 4 * w;
`ifndef ALIGN_CHECK_EN
            a = a + ($urandom & 3);
`endif
            words.push_back(w);
            access(1'b0, 1'b1, a, d, 1'b0);
            w = words[$urandom_range(0, words.size() - 1)];
            access(1'b1, 1'b0, BASE + 4 * w, 32'h0, 1'b0);
        end

        // Unaligned load at 1026.
`ifdef ALIGN_CHECK_EN
        mem_r_en   = 1'b1;
        alu_result = 32'd1026;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("misalign_freeze k=%0d", k), {31'd0, freeze}, 32'd0);
            check($sformatf("misalign_we_n k=%0d", k), {31'd0, sram_we_n}, 32'd1);
            check($sformatf("misalign_oe_n k=%0d", k), {31'd0, sram_oe_n}, 32'd1);
            if (k > 0) check($sformatf("misalign_err k=%0d", k), {31'd0, mem_err}, 32'd1);
            @(posedge clk);
            #1;
        end
        mem_r_en = 1'b0;
`else
        access(1'b1, 1'b0, 32'd1026, 32'h0, 1'b0);
`endif

        // Reset during the HIGH phase of a store.
        mem_w_en   = 1'b1;
        alu_result = BASE + 4 * 50;
        val_rm     = $urandom;
        repeat (W + 3) @(posedge clk);
        #1;
        check("mid_we_n_pre", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_we_n", {31'd0, sram_we_n}, 32'd1);
        check("mid_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("mid_freeze", {31'd0, freeze}, 32'd0);
        check("mid_result", mem_result, 32'd0);
        exp_load = '0;
        mem_w_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_freeze", {31'd0, freeze}, 32'd0);
        check("post_rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_sram_access.md
Name: mem_sram_access

Overview:
- Memory-stage consumer of the execute stage's outputs: ALU result as byte address, Rm value as store data, and the memory read/write enables.
- Performs 32-bit loads and stores on an external 16-bit-wide asynchronous SRAM as two halfword phases with programmable wait states.
- Asserts freeze to stall the pipeline while an access is in flight, and returns load data to writeback.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM halfword 0.
- WAIT_CYCLES, 4: extra cycles per halfword phase; each phase lasts WAIT_CYCLES+1 cycles.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = in reset).
- mem_r_en  in  1  load request from EXE/MEM register.
- mem_w_en  in  1  store request from EXE/MEM register.
- alu_result  in  32  byte address.
- val_rm  in  32  store data.
- mem_result  out  32  load data; registered.
- freeze  out  1  pipeline stall; combinational from state and requests.
- sram_addr  out  18  halfword address; registered.
- sram_dq_out  out  16  write data; registered.
- sram_dq_in  in  16  read data from the SRAM.
- sram_dq_oe  out  1  1 = drive sram_dq_out onto the bus; registered.
- sram_we_n  out  1  active-low write strobe; registered.
- sram_oe_n  out  1  active-low output enable; registered.

Behaviour:
- Reset values:
  - mem_result = 0, sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0.
  - sram_we_n = 1, sram_oe_n = 1.
  - State = IDLE, counter = 0.
  - freeze = 0 while in reset.
- Address translation:
  - word = (alu_result - BASE_ADDR) >> 2, truncated to 17 bits.
  - Low phase uses sram_addr = {word, 0}; high phase uses {word, 1}.
  - alu_result[1:0] are ignored.
- Data ordering (little-endian): low phase carries bits [15:0], high phase carries bits [31:16].
- Request priority: if mem_r_en and mem_w_en are both 1, the access is a store.
- IDLE:
  - With a request: freeze = 1. Next state LOW; the registered SRAM outputs load the LOW values at that edge.
  - Without a request: freeze = 0 and no SRAM activity.
- LOW:
  - Lasts WAIT_CYCLES+1 cycles, counted by counter 0..WAIT_CYCLES; freeze = 1.
  - Store: sram_we_n = 0, sram_dq_oe = 1, sram_dq_out = val_rm[15:0].
  - Load: sram_oe_n = 0; sram_dq_in is captured into the low half on the last LOW cycle.
  - Next state HIGH; counter returns to 0.
- HIGH:
  - Same as LOW, using the odd address and bits [31:16].
  - For loads, the capture on the last HIGH cycle completes mem_result.
  - Next state DONE.
- DONE:
  - Exactly 1 cycle. freeze = 0, all SRAM strobes inactive, sram_dq_oe = 0.
  - mem_result is valid (it was updated at the end of HIGH).
  - Next state IDLE unconditionally; a new request is evaluated in IDLE.
- Latency:
  - freeze is high for 1 + 2*(WAIT_CYCLES+1) cycles (11 at the default).
  - Back-to-back accesses have exactly one freeze-low cycle (DONE) between them.
- Input stability: alu_result, val_rm and the enables are stable while freeze = 1, because the upstream registers are frozen. Changes are not sampled after IDLE.
- Store results: mem_result is unchanged by stores and holds the last load value.
- Counter wrap: WAIT_CYCLES = 0 gives 1-cycle phases; the counter never exceeds WAIT_CYCLES.
- Reset mid-access:
  - Immediate return to reset values, with no completion.
  - A store interrupted after LOW leaves only the low halfword written; this is accepted.

Optional Feature:
- ALIGN_CHECK_EN defined:
  - Adds output mem_err (1 bit, sticky, reset 0).
  - A request in IDLE with alu_result[1:0] != 0 or alu_result < BASE_ADDR sets mem_err.
  - Such a request performs no SRAM access and freeze stays 0.
- ALIGN_CHECK_EN undefined: no mem_err port; all requests are translated and executed as above.

Decomposition:
- Shared package holds:
  - State enum: IDLE, LOW, HIGH, DONE.
  - Constants SRAM_AW = 18 and SRAM_DW = 16.
  - Default BASE_ADDR.
- One combinational sub-module, sram_addr_xlate: byte address plus phase in, halfword address out (plus the alignment flag when ALIGN_CHECK_EN is defined).
- The FSM, counter and data registers live in the top module.

Test Plan:
- Store 0xDEADBEEF to 1024 -> halfword 0 written with 0xBEEF, then halfword 1 with 0xDEAD. sram_we_n is low for 5 cycles per phase and freeze is high for 11 cycles.
- Load from 1024 with an SRAM model holding that data -> mem_result = 0xDEADBEEF in the DONE cycle, freeze high for 11 cycles, sram_we_n held at 1.
- Store 0x12345678 to 1036 -> sram_addr 6 receives 0x5678 and sram_addr 7 receives 0x1234. A load from 1036 returns 0x12345678.
- Load immediately followed by store (enables held) -> freeze is low for exactly one cycle between the two 11-cycle stalls. mem_result is unchanged by the store.
- Deassert rst during the HIGH phase of a store -> in the same cycle sram_we_n = 1, sram_dq_oe = 0, freeze = 0. After release the block is in IDLE.
- With ALIGN_CHECK_EN, load from 1026 -> mem_err = 1, freeze = 0, no strobes. Without the macro, the same load accesses halfwords 0 and 1.
